// File: rtl/wb_arb_pkg.sv
// Shared constants and state encoding for the Wishbone bus arbiter.
package wb_arb_pkg;

  localparam int WB_ADDR_WIDTH = 32;
  localparam int WB_DATA_WIDTH = 32;
  localparam int MAX_MASTERS   = 8;
  localparam int IDX_W         = $clog2(MAX_MASTERS);

  localparam logic [31:0] DEFAULT_TIMEOUT_RDATA = 32'hDEAD_BEEF;

  typedef logic [0:0] arb_state_t;
  localparam arb_state_t IDLE = 1'b0;
  localparam arb_state_t BUSY = 1'b1;

endpackage

// File: rtl/wb_arb_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping.
module wb_arb_rr_picker
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [IDX_W-1:0]       ptr_i,
  output logic [NUM_MASTERS-1:0] gnt_oh_o,
  output logic [IDX_W-1:0]       gnt_idx_o
);

  // Lowest requester below ptr is the fallback; any requester at or above ptr overrides it.
  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (req_i[k] && (k < int'(ptr_i))) begin
        gnt_oh_o    = '0;
        gnt_oh_o[k] = 1'b1;
        gnt_idx_o   = IDX_W'(k);
      end
    end
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (req_i[k] && (k >= int'(ptr_i))) begin
        gnt_oh_o    = '0;
        gnt_oh_o[k] = 1'b1;
        gnt_idx_o   = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Round-robin Wishbone arbiter: N masters onto one slave port, ownership held for
// the owner's whole cyc, with a watchdog that fake-acks stalled accesses.
module wb_bus_arbiter
  import wb_arb_pkg::*;
#(
  parameter int                    NUM_MASTERS    = 2,
  parameter int                    ADDR_WIDTH     = WB_ADDR_WIDTH,
  parameter int                    DATA_WIDTH     = WB_DATA_WIDTH,
  parameter int                    TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_RDATA  = DATA_WIDTH'(DEFAULT_TIMEOUT_RDATA)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]    m_addr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_wdata_i,
  input  logic [NUM_MASTERS-1:0]               m_wr_en_i,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]  m_byte_en_i,
  input  logic [NUM_MASTERS-1:0]               m_stb_i,
  input  logic [NUM_MASTERS-1:0]               m_cyc_i,
  output logic [NUM_MASTERS-1:0]               m_ack_o,
  output logic [DATA_WIDTH-1:0]                m_rdata_o,
  output logic [ADDR_WIDTH-1:0]                s_addr_o,
  output logic [DATA_WIDTH-1:0]                s_wdata_o,
  output logic                                 s_wr_en_o,
  output logic [DATA_WIDTH/8-1:0]              s_byte_en_o,
  output logic                                 s_stb_o,
  output logic                                 s_cyc_o,
  input  logic [DATA_WIDTH-1:0]                s_rdata_i,
  input  logic                                 s_ack_i,
  output logic [NUM_MASTERS-1:0]               grant_o,
  output logic                                 timeout_o,
  output logic [2:0]                           timeout_id_o,
  input  logic                                 timeout_clr_i
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  arb_state_t             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0]       wd_cnt_q, wd_cnt_d;
  logic                   timeout_q, timeout_d;
  logic [2:0]             timeout_id_q, timeout_id_d;

  logic [NUM_MASTERS-1:0] pick_oh;
  logic [IDX_W-1:0]       pick_idx;
  logic                   own_cyc;
  logic                   own_stb;
  logic                   wd_fire;

  wb_arb_rr_picker #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_picker (
    .req_i     (m_cyc_i),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (pick_oh),
    .gnt_idx_o (pick_idx)
  );

  // Slave-side mux; grant_q is all-zero outside BUSY so idle outputs fall to zero.
  always_comb begin
    s_addr_o    = '0;
    s_wdata_o   = '0;
    s_wr_en_o   = 1'b0;
    s_byte_en_o = '0;
    own_cyc     = 1'b0;
    own_stb     = 1'b0;
    if (state_q == BUSY) begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
        if (grant_q[k]) begin
          s_addr_o    = m_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
          s_wdata_o   = m_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
          s_wr_en_o   = m_wr_en_i[k];
          s_byte_en_o = m_byte_en_i[k*BE_WIDTH +: BE_WIDTH];
          own_cyc     = m_cyc_i[k];
          own_stb     = m_stb_i[k];
        end
      end
    end
  end

  // A real ack in the final watchdog cycle suppresses the forced termination.
  assign wd_fire = (TIMEOUT_CYCLES != 0) && own_stb && !s_ack_i && (wd_cnt_q == CNT_LAST);

  assign s_cyc_o      = own_cyc;
  assign s_stb_o      = own_stb & ~wd_fire;
  assign m_ack_o      = grant_q & {NUM_MASTERS{s_ack_i | wd_fire}};
  assign m_rdata_o    = (state_q != BUSY) ? '0 : (wd_fire ? TIMEOUT_RDATA : s_rdata_i);
  assign grant_o      = grant_q;
  assign timeout_o    = timeout_q;
  assign timeout_id_o = timeout_id_q;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    ptr_d        = ptr_q;
    timeout_d    = timeout_q;
    timeout_id_d = timeout_id_q;
    case (state_q)
      IDLE: begin
        if (|m_cyc_i) begin
          state_d = BUSY;
          grant_d = pick_oh;
          owner_d = pick_idx;
          ptr_d   = (pick_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : pick_idx + IDX_W'(1);
        end
      end
      BUSY: begin
        if (!own_cyc) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    wd_cnt_d = (own_stb && !s_ack_i && !wd_fire) ? wd_cnt_q + CNT_W'(1) : '0;
    if (timeout_clr_i) begin
      timeout_d = 1'b0;
    end
    if (wd_fire) begin
      timeout_d    = 1'b1;
      timeout_id_d = 3'(owner_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      ptr_q        <= '0;
      wd_cnt_q     <= '0;
      timeout_q    <= 1'b0;
      timeout_id_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      ptr_q        <= ptr_d;
      wd_cnt_q     <= wd_cnt_d;
      timeout_q    <= timeout_d;
      timeout_id_q <= timeout_id_d;
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter (2 masters, 8-cycle watchdog) with an ack scoreboard.
module tb_wb_bus_arbiter;

  typedef struct {
    logic [1:0]  ack;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ma  [2];
  logic [31:0] mw  [2];
  logic [3:0]  mbe [2];
  logic [1:0]  mwe;
  logic [1:0]  m_stb;
  logic [1:0]  m_cyc;
  logic [1:0]  m_ack;
  logic [31:0] m_rdata;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic        s_wr_en;
  logic [3:0]  s_be;
  logic        s_stb;
  logic        s_cyc;
  logic [31:0] s_rdata;
  logic        s_ack;
  logic [1:0]  grant;
  logic        tmo;
  logic [2:0]  tmo_id;
  logic        tmo_clr;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  wb_bus_arbiter #(
    .NUM_MASTERS    (2),
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (8),
    .TIMEOUT_RDATA  (32'hDEAD_BEEF)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .m_addr_i      ({ma[1], ma[0]}),
    .m_wdata_i     ({mw[1], mw[0]}),
    .m_wr_en_i     (mwe),
    .m_byte_en_i   ({mbe[1], mbe[0]}),
    .m_stb_i       (m_stb),
    .m_cyc_i       (m_cyc),
    .m_ack_o       (m_ack),
    .m_rdata_o     (m_rdata),
    .s_addr_o      (s_addr),
    .s_wdata_o     (s_wdata),
    .s_wr_en_o     (s_wr_en),
    .s_byte_en_o   (s_be),
    .s_stb_o       (s_stb),
    .s_cyc_o       (s_cyc),
    .s_rdata_i     (s_rdata),
    .s_ack_i       (s_ack),
    .grant_o       (grant),
    .timeout_o     (tmo),
    .timeout_id_o  (tmo_id),
    .timeout_clr_i (tmo_clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every ack the DUT presents must match the next expected entry.
  always @(negedge clk) begin
    if (|m_ack) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ack: got ack %b rdata %h, required no ack (t=%0t)",
                 m_ack, m_rdata, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("ack_vec", 32'(m_ack), 32'(mon_e.ack));
        check("ack_rdata", m_rdata, mon_e.rdata);
      end
    end
  end

  task automatic do_reset();
    rst     = 1'b1;
    m_cyc   = '0;
    m_stb   = '0;
    mwe     = '0;
    s_ack   = 1'b0;
    s_rdata = '0;
    tmo_clr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ma[i]  = '0;
      mw[i]  = '0;
      mbe[i] = '0;
    end
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // One beat by the current owner k; slave acks 'delay' cycles after stb rises.
  task automatic run_beat(input logic k, input logic [31:0] addr, input logic we,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input int delay, input logic [31:0] rdata);
    ma[k]    = addr;
    mw[k]    = wdata;
    mwe[k]   = we;
    mbe[k]   = be;
    m_stb[k] = 1'b1;
    #1;
    check("s_addr", s_addr, addr);
    check("s_wdata", s_wdata, wdata);
    check("s_wr_en", 32'(s_wr_en), 32'(we));
    check("s_byte_en", 32'(s_be), 32'(be));
    check("s_stb", 32'(s_stb), 32'd1);
    repeat (delay) tick();
    exp_q.push_back('{ack: (k ? 2'b10 : 2'b01), rdata: rdata});
    s_rdata = rdata;
    s_ack   = 1'b1;
    tick();
    s_ack    = 1'b0;
    s_rdata  = '0;
    m_stb[k] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not finish within time limit");
    $fatal(1, "bench timeout");
  end

  initial begin
    do_reset();
    #1;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_s_cyc", 32'(s_cyc), 32'd0);
    check("rst_s_stb", 32'(s_stb), 32'd0);
    check("rst_timeout", 32'(tmo), 32'd0);
    check("rst_timeout_id", 32'(tmo_id), 32'd0);
    check("rst_m_ack", 32'(m_ack), 32'd0);
    check("rst_m_rdata", m_rdata, 32'd0);

    // Single master 0 write
    m_cyc[0] = 1'b1;
    #1;
    check("t1_idle_s_cyc", 32'(s_cyc), 32'd0);
    tick();
    #1;
    check("t1_grant", 32'(grant), 32'd1);
    check("t1_s_cyc", 32'(s_cyc), 32'd1);
    run_beat(1'b0, 32'h0300_0010, 1'b1, 32'h1234_5678, 4'hF, 2, 32'h0);
    m_cyc[0] = 1'b0;
    #1;
    check("t1_s_cyc_drop", 32'(s_cyc), 32'd0);
    check("t1_grant_hold", 32'(grant), 32'd1);
    tick();
    #1;
    check("t1_grant_idle", 32'(grant), 32'd0);

    // Simultaneous requests from reset
    do_reset();
    m_cyc = 2'b11;
    tick();
    #1;
    check("t2_first_grant", 32'(grant), 32'd1);
    run_beat(1'b0, 32'h1000_0000, 1'b0, 32'h0, 4'hF, 1, 32'hAAAA_0001);
    m_cyc[0] = 1'b0;
    #1;
    check("t2_s_cyc_drop", 32'(s_cyc), 32'd0);
    tick();
    #1;
    check("t2_gap_grant", 32'(grant), 32'd0);
    tick();
    #1;
    check("t2_second_grant", 32'(grant), 32'd2);
    run_beat(1'b1, 32'h2000_0000, 1'b0, 32'h0, 4'h3, 1, 32'hBBBB_0002);
    m_cyc[1] = 1'b0;
    tick();
    m_cyc[0] = 1'b1;
    tick();
    #1;
    check("t2_solo_grant", 32'(grant), 32'd1);
    run_beat(1'b0, 32'h3000_0000, 1'b0, 32'h0, 4'hF, 0, 32'hCCCC_0003);
    m_cyc[0] = 1'b0;
    tick();
    m_cyc = 2'b11;
    tick();
    #1;
    check("t2_round2_first", 32'(grant), 32'd2);
    run_beat(1'b1, 32'h2000_0004, 1'b1, 32'h0BAD_F00D, 4'hC, 1, 32'h0);
    m_cyc[1] = 1'b0;
    tick();
    tick();
    #1;
    check("t2_round2_second", 32'(grant), 32'd1);
    run_beat(1'b0, 32'h3000_0004, 1'b0, 32'h0, 4'hF, 0, 32'hCCCC_0004);
    m_cyc[0] = 1'b0;
    tick();

    // Master 1 waits while master 0 runs a 4-beat burst
    m_cyc[0] = 1'b1;
    tick();
    #1;
    check("t3_grant0", 32'(grant), 32'd1);
    m_cyc[1] = 1'b1;
    ma[1]    = 32'h5555_0000;
    for (int i = 0; i < 4; i++) begin
      run_beat(1'b0, 32'h4000_0000 + 32'(i * 4), 1'b1, 32'h0100_0000 + 32'(i), 4'hF, 1, 32'h0);
      check("t3_grant_hold", 32'(grant), 32'd1);
    end
    m_cyc[0] = 1'b0;
    tick();
    tick();
    #1;
    check("t3_grant1", 32'(grant), 32'd2);
    run_beat(1'b1, 32'h5555_0000, 1'b1, 32'h5555_AAAA, 4'hF, 0, 32'h0);
    m_cyc[1] = 1'b0;
    tick();

    // Watchdog: master 1, slave never acks
    m_cyc[1] = 1'b1;
    m_stb[1] = 1'b1;
    mwe[1]   = 1'b0;
    ma[1]    = 32'h6000_0000;
    tick();
    #1;
    check("t4_grant", 32'(grant), 32'd2);
    exp_q.push_back('{ack: 2'b10, rdata: 32'hDEAD_BEEF});
    repeat (7) tick();
    #1;
    check("t4_stb_forced", 32'(s_stb), 32'd0);
    check("t4_cyc_held", 32'(s_cyc), 32'd1);
    check("t4_flag_pre", 32'(tmo), 32'd0);
    tick();
    #1;
    check("t4_flag", 32'(tmo), 32'd1);
    check("t4_flag_id", 32'(tmo_id), 32'd1);
    m_stb[1] = 1'b0;
    tmo_clr  = 1'b1;
    tick();
    tmo_clr = 1'b0;
    #1;
    check("t4_flag_clr", 32'(tmo), 32'd0);
    m_cyc[1] = 1'b0;
    tick();

    // Real ack on the final watchdog cycle wins
    m_cyc[0] = 1'b1;
    tick();
    run_beat(1'b0, 32'h7000_0000, 1'b0, 32'h0, 4'hF, 7, 32'h5A5A_1234);
    #1;
    check("t5_no_flag", 32'(tmo), 32'd0);
    m_cyc[0] = 1'b0;
    tick();

    // Reset mid-transfer
    m_cyc[1] = 1'b1;
    m_stb[1] = 1'b1;
    ma[1]    = 32'h7100_0000;
    tick();
    #1;
    check("t6_grant1", 32'(grant), 32'd2);
    check("t6_s_cyc", 32'(s_cyc), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    #1;
    check("t6_rst_s_cyc", 32'(s_cyc), 32'd0);
    check("t6_rst_s_stb", 32'(s_stb), 32'd0);
    check("t6_rst_grant", 32'(grant), 32'd0);
    check("t6_rst_ack", 32'(m_ack), 32'd0);
    rst      = 1'b0;
    m_cyc[0] = 1'b1;
    tick();
    #1;
    check("t6_prio_m0", 32'(grant), 32'd1);
    m_cyc    = 2'b00;
    m_stb    = 2'b00;
    tick();
    #1;
    check("t6_final_idle", 32'(grant), 32'd0);
    tick();

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Shares the single Wishbone master port of cv32e40x_soc (wb_addr_o … wb_cyc_o) between N Wishbone masters, e.g. the OBI-to-WB bridge and a debug/DMA master.
- Uses round-robin arbitration with bus ownership held for the whole cyc_i cycle.
- A watchdog terminates stalled slave accesses with a fake ack.
- Sits between the masters and the peripheral interconnect / wfg register bus.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8).
- ADDR_WIDTH, 32, Wishbone address width.
- DATA_WIDTH, 32, Wishbone data width; byte enables are DATA_WIDTH/8 bits.
- TIMEOUT_CYCLES, 255, cycles of stb without ack before forced termination; 0 disables the watchdog.
- TIMEOUT_RDATA, 32'hDEAD_BEEF, read data returned on a forced termination.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- m_addr_i  in  NUM_MASTERS*ADDR_WIDTH  master addresses, master k at slice k
- m_wdata_i  in  NUM_MASTERS*DATA_WIDTH  master write data
- m_wr_en_i  in  NUM_MASTERS  write enables
- m_byte_en_i  in  NUM_MASTERS*DATA_WIDTH/8  byte enables
- m_stb_i  in  NUM_MASTERS  strobes
- m_cyc_i  in  NUM_MASTERS  cycle/request signals
- m_ack_o  out  NUM_MASTERS  acks; only the owner's bit can be 1
- m_rdata_o  out  DATA_WIDTH  read data, broadcast to all masters
- s_addr_o  out  ADDR_WIDTH  to slave
- s_wdata_o  out  DATA_WIDTH  to slave
- s_wr_en_o  out  1  to slave
- s_byte_en_o  out  DATA_WIDTH/8  to slave
- s_stb_o  out  1  to slave
- s_cyc_o  out  1  to slave
- s_rdata_i  in  DATA_WIDTH  from slave
- s_ack_i  in  1  from slave
- grant_o  out  NUM_MASTERS  one-hot owner; 0 when idle
- timeout_o  out  1  sticky watchdog flag
- timeout_id_o  out  3  index of the master whose access timed out
- timeout_clr_i  in  1  clears timeout_o

Behaviour:
- Clocking/reset: one clock, clk_i; rst_i is synchronous and active-high.
- Reset values: state=IDLE, grant_o=0, RR pointer=0, watchdog counter=0, timeout_o=0, timeout_id_o=0.
- Reset consequences: all s_* outputs and m_ack_o are 0; m_rdata_o=0. A reset during a BUSY transfer drops s_cyc_o/s_stb_o on the next edge with no ack issued.
- FSM IDLE:
  - Requests are the m_cyc_i bits (stb not required).
  - If any request: at the clock edge, register a one-hot grant for the winner and go to BUSY.
  - Winner is the first requester at or after index (ptr) going upward and wrapping.
  - ptr <= winner+1 mod NUM_MASTERS.
  - No request: stay in IDLE.
- FSM BUSY:
  - s_* outputs are a combinational mux of the owner's inputs; s_cyc_o = owner cyc.
  - m_ack_o[owner] = s_ack_i; m_rdata_o = s_rdata_i.
  - Non-owners see ack 0 and are stalled.
  - Owner cyc_i low → IDLE at the next edge; slave cyc is deasserted immediately through the mux.
- IDLE s_* outputs: all zero.
- Latency:
  - Request in IDLE at cycle n → s_cyc_o at n+1.
  - Owner drops cyc at cycle m → the earliest next grant is visible at m+2; there is always ≥1 idle cycle between owners.
- Fairness: with all masters requesting back-to-back, grants rotate 0,1,…,N-1,0. Requests arriving while BUSY are queued implicitly (masters hold cyc).
- Watchdog counter:
  - Counts in BUSY while s_stb_o=1 and s_ack_i=0.
  - Reset to 0 on s_ack_i, on leaving BUSY, and when stb is low.
- Watchdog termination, when the counter reaches TIMEOUT_CYCLES−1 without ack, in that cycle:
  - m_ack_o[owner]=1 and m_rdata_o=TIMEOUT_RDATA.
  - s_stb_o is forced to 0.
  - timeout_o<=1 and timeout_id_o<=owner at the edge.
- Watchdog coincidences:
  - Real s_ack_i in the same cycle as termination wins: real data, no flag.
  - timeout_clr_i and a new timeout in the same cycle: the set wins.
  - TIMEOUT_CYCLES=0: the counter is never checked.
- Byte enables and address pass unmodified; there are no width conversions.

Decomposition:
- Package wb_arb_pkg:
  - state enum {IDLE, BUSY};
  - WB_ADDR_WIDTH=32 and WB_DATA_WIDTH=32 constants;
  - MAX_MASTERS=8;
  - default TIMEOUT_RDATA.
- Sub-module wb_arb_rr_picker: combinational round-robin; inputs req vector and ptr, outputs one-hot winner and index. The rest lives in wb_bus_arbiter.

Test Plan:
- Single master 0 write: addr 0x0300_0010, wdata 0x1234_5678, slave ack 2 cycles after stb → s_cyc_o rises 1 cycle after m_cyc_i[0]; m_ack_o=2'b01 for exactly one cycle; grant_o returns to 0 one cycle after cyc drops.
- Both masters request simultaneously from reset → master 0 granted first, master 1 granted 2 cycles after master 0 drops cyc; a second simultaneous round grants master 1 first.
- Master 1 asserts cyc while master 0 owns a 4-beat burst → s_addr_o follows master 0 only; m_ack_o[1]=0 throughout; master 1 is granted afterwards.
- Slave never acks, TIMEOUT_CYCLES=8 → m_ack_o[owner] pulses 8 cycles after stb with m_rdata_o=0xDEADBEEF; timeout_o=1, timeout_id_o=owner; timeout_clr_i pulse → timeout_o=0.
- Real ack on the final watchdog cycle → real s_rdata_i returned; timeout_o stays 0.
- rst_i asserted mid-transfer → next cycle s_cyc_o=0, grant_o=0, no ack; after release master 0 has priority again.
